// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults, byte-lane enables and CLEAR/RUN state encoding for the data memory.
package dmem_pkg;
    localparam int DMEM_ADDR_WIDTH_DEF = 12;
    localparam int DMEM_WORD_WIDTH_DEF = 16;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: 16-bit word array, one byte-enabled write port, one registered write-first read port.
// Ports: clock; wr_en/wr_be/wr_idx/wr_data write port; rd_idx read index; rd_data word read (1-cycle latency).
module dmem_ram #(
    parameter int IW = 11
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [1:0]    wr_be,
    input  logic [IW-1:0] wr_idx,
    input  logic [15:0]   wr_data,
    input  logic [IW-1:0] rd_idx,
    output logic [15:0]   rd_data
);
    logic [15:0] mem [0:(1<<IW)-1];
    logic [15:0] old_word, rd_data_d, rd_data_q;
    logic        hit;
    // A same-index write overrides only the lanes it enables; the other lane keeps its old value.
    always_comb begin
        old_word  = mem[rd_idx];
        hit       = wr_en && (wr_idx == rd_idx);
        rd_data_d = {hit && wr_be[1] ? wr_data[15:8] : old_word[15:8],
                     hit && wr_be[0] ? wr_data[7:0]  : old_word[7:0]};
    end
    always_ff @(posedge clock) begin
        if (wr_en && wr_be[1]) mem[wr_idx][15:8] <= wr_data[15:8];
        if (wr_en && wr_be[0]) mem[wr_idx][7:0]  <= wr_data[7:0];
        rd_data_q <= rd_data_d;
    end
    assign rd_data = rd_data_q;
endmodule

// File: rtl/dmem.sv
// dmem: byte-addressed 16-bit data memory with byte/word stores, write-first reads and optional clear-on-reset.
// Ports: clock, reset (async, active-high); in_rd_addr byte read address; in_wr_addr/in_wr_word/in_wr_en/in_wr_byte
// store request; out_rd_word registered read word; out_ready array usable; out_misaligned pulse for odd word store.
// Macro DMEM_CLEAR_ON_RESET_EN: when defined, reset enters CLEAR and zeroes every word before RUN.
module dmem
    import dmem_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = DMEM_ADDR_WIDTH_DEF,
    parameter int DMEM_WORD_WIDTH = DMEM_WORD_WIDTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_wr_word,
    input  logic                       in_wr_en,
    input  logic                       in_wr_byte,
    output logic [DMEM_WORD_WIDTH-1:0] out_rd_word,
    output logic                       out_ready,
    output logic                       out_misaligned
);
    localparam int IW = DMEM_ADDR_WIDTH - 1;
    logic          clear, store, mis_d, mis_q, rd_valid_d, rd_valid_q;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [IW-1:0] ram_idx, clr_idx;
    logic [15:0]   ram_wd, ram_rd;
    logic          rd_lsb_unused;
    assign rd_lsb_unused = in_rd_addr[0];
`ifdef DMEM_CLEAR_ON_RESET_EN
    state_t        state_d, state_q;
    logic [IW-1:0] clr_cnt_d, clr_cnt_q;
    always_comb begin
        clr_cnt_d = (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : clr_cnt_q;
        state_d   = (state_q == ST_CLEAR) && (&clr_cnt_q) ? ST_RUN : state_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
    assign clear     = state_q == ST_CLEAR;
    assign clr_idx   = clr_cnt_q;
    assign out_ready = state_q == ST_RUN;
`else
    assign clear     = 1'b0;
    assign clr_idx   = '0;
    assign out_ready = 1'b1;
`endif
    // The clear sweep owns the write port; user stores are ignored until RUN.
    always_comb begin
        store      = in_wr_en && out_ready;
        ram_we     = clear || store;
        ram_idx    = clear ? clr_idx : in_wr_addr[DMEM_ADDR_WIDTH-1:1];
        ram_be     = (clear || !in_wr_byte) ? LANE_BOTH : (in_wr_addr[0] ? LANE_HI : LANE_LO);
        ram_wd     = clear ? 16'h0000 : (in_wr_byte ? {2{in_wr_word[7:0]}} : in_wr_word[15:0]);
        mis_d      = store && !in_wr_byte && in_wr_addr[0];
        rd_valid_d = out_ready;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mis_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            mis_q      <= mis_d;
            rd_valid_q <= rd_valid_d;
        end
    end
    dmem_ram #(.IW(IW)) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_be   (ram_be),
        .wr_idx  (ram_idx),
        .wr_data (ram_wd),
        .rd_idx  (in_rd_addr[DMEM_ADDR_WIDTH-1:1]),
        .rd_data (ram_rd)
    );
    // The array's read register has no reset, so its value is hidden until a read was sampled in RUN.
    assign out_rd_word    = rd_valid_q ? ram_rd : '0;
    assign out_misaligned = mis_q;
endmodule
